// File: rtl/io_wait_controller_pkg.sv
// Shared definitions for the blocking-input wait controller:
// I/O opcodes, FSM state encoding and the opcode field extractor.
package io_wait_controller_pkg;

  localparam int unsigned OP_W = 6;

  // Opcodes of the two blocking input instructions
  localparam logic [OP_W-1:0] OP_INPUTB  = 6'h30;
  localparam logic [OP_W-1:0] OP_READKEY = 6'h31;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RX  = 2'd1,
    ST_WAIT_KEY = 2'd2
  } wait_state_e;

  // Opcode lives in the top six bits of the instruction word
  function automatic logic [OP_W-1:0] inst_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with drop-on-full and a sticky overflow flag.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, push_data  write strobe and data (dropped when full without a pop)
//   pop              read strobe (ignored when empty)
//   ovf_clr          clears overflow; a same-cycle drop keeps it set
//   head             oldest entry (valid when !empty)
//   full, empty      occupancy flags
//   count            occupancy, 0..DEPTH
//   overflow         sticky: a push was dropped
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/io_wait_controller.sv
// Blocking input controller for INPUTB (UART RX) and READKEY (keyboard).
// Buffers each source in a FIFO, freezes the pipeline while the decode-stage
// instruction has no data, and pops one entry per advancing instruction.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   inst, inst_valid         decode-stage instruction and its valid flag
//   advance                  decode moves forward this cycle
//   rx_push, rx_byte         UART receive strobe/data
//   key_push, key_code       keyboard strobe/scan code
//   ovf_clr                  clears both overflow flags
//   freeze                   combinational stall request (0 during reset)
//   io_data, io_data_valid   popped value for writeback, one cycle after pop
//   rx_overflow, key_overflow sticky drop flags
//   rx_count                 RX FIFO occupancy
//   wait_cycles              saturating count of cycles spent waiting
module io_wait_controller
  import io_wait_controller_pkg::*;
#(
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned KEY_DEPTH  = 4,
  parameter int unsigned WAIT_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 inst,
  input  logic                        inst_valid,
  input  logic                        advance,
  input  logic                        rx_push,
  input  logic [7:0]                  rx_byte,
  input  logic                        key_push,
  input  logic [7:0]                  key_code,
  input  logic                        ovf_clr,
  output logic                        freeze,
  output logic [7:0]                  io_data,
  output logic                        io_data_valid,
  output logic                        rx_overflow,
  output logic                        key_overflow,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [WAIT_CNT_W-1:0]       wait_cycles
);

  localparam int unsigned DATA_W = 8;

  wait_state_e state;
  wait_state_e state_d;

  logic [OP_W-1:0]              op;
  logic                         is_rx;
  logic                         is_key;
  logic                         pop_rx;
  logic                         pop_key;
  logic [DATA_W-1:0]            rx_head;
  logic [DATA_W-1:0]            key_head;
  logic                         rx_empty;
  logic                         key_empty;
  logic                         rx_full_unused;
  logic                         key_full_unused;
  logic [$clog2(KEY_DEPTH):0]   key_count_unused;
  logic                         inst_low_unused;

  // Only the opcode field matters here
  assign inst_low_unused = ^inst[25:0];

  assign op     = inst_op(inst);
  assign is_rx  = inst_valid && (op == OP_INPUTB);
  assign is_key = inst_valid && (op == OP_READKEY);

  // Registered occupancy: a same-cycle push does not release the stall
  assign freeze = rst_n && ((is_rx && rx_empty) || (is_key && key_empty));

  assign pop_rx  = is_rx && !rx_empty && advance;
  assign pop_key = is_key && !key_empty && advance;

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_byte),
    .pop       (pop_rx),
    .ovf_clr   (ovf_clr),
    .head      (rx_head),
    .full      (rx_full_unused),
    .empty     (rx_empty),
    .count     (rx_count),
    .overflow  (rx_overflow)
  );

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (KEY_DEPTH)
  ) u_key_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (key_push),
    .push_data (key_code),
    .pop       (pop_key),
    .ovf_clr   (ovf_clr),
    .head      (key_head),
    .full      (key_full_unused),
    .empty     (key_empty),
    .count     (key_count_unused),
    .overflow  (key_overflow)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state re-derived from the current instruction every cycle, so a
  // flush, bubble or data arrival all fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    if (is_rx && rx_empty) begin
      state_d = ST_WAIT_RX;
    end else if (is_key && key_empty) begin
      state_d = ST_WAIT_KEY;
    end
  end

  // Writeback data; the opcodes are exclusive so at most one pop per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_data       <= '0;
      io_data_valid <= 1'b0;
    end else begin
      io_data_valid <= pop_rx || pop_key;
      if (pop_rx) begin
        io_data <= rx_head;
      end else if (pop_key) begin
        io_data <= key_head;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cycles <= '0;
    end else if ((state != ST_IDLE) && (wait_cycles != {WAIT_CNT_W{1'b1}})) begin
      wait_cycles <= wait_cycles + WAIT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_io_wait_controller.sv
// Scoreboard bench for io_wait_controller: per-source FIFO models feed an
// expected-output queue that a negedge monitor checks against io_data.
module tb_io_wait_controller;
  import io_wait_controller_pkg::*;

  localparam int unsigned RX_DEPTH   = 16;
  localparam int unsigned KEY_DEPTH  = 4;
  localparam int unsigned WAIT_CNT_W = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        advance;
  logic        rx_push;
  logic [7:0]  rx_byte;
  logic        key_push;
  logic [7:0]  key_code;
  logic        ovf_clr;
  logic        freeze;
  logic [7:0]  io_data;
  logic        io_data_valid;
  logic        rx_overflow;
  logic        key_overflow;
  logic [4:0]  rx_count;
  logic [WAIT_CNT_W-1:0] wait_cycles;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] key_model[$];
  logic [7:0] mon_exp;

  io_wait_controller #(
    .RX_DEPTH   (RX_DEPTH),
    .KEY_DEPTH  (KEY_DEPTH),
    .WAIT_CNT_W (WAIT_CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .advance       (advance),
    .rx_push       (rx_push),
    .rx_byte       (rx_byte),
    .key_push      (key_push),
    .key_code      (key_code),
    .ovf_clr       (ovf_clr),
    .freeze        (freeze),
    .io_data       (io_data),
    .io_data_valid (io_data_valid),
    .rx_overflow   (rx_overflow),
    .key_overflow  (key_overflow),
    .rx_count      (rx_count),
    .wait_cycles   (wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Output monitor: every writeback strobe must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && io_data_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL io_data_unexpected: got %02h with valid, required no output", io_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (io_data !== mon_exp) begin
          n_err++;
          $display("FAIL io_data_order: got %02h, required %02h", io_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and advance the reference models accordingly
  task automatic cycle(input bit rp, input logic [7:0] rb, input bit kp, input logic [7:0] kb,
                       input logic [5:0] op, input bit v, input bit adv);
    inst       = {op, 26'h2AAAAAA};
    inst_valid = v;
    advance    = adv;
    rx_push    = rp;
    rx_byte    = rb;
    key_push   = kp;
    key_code   = kb;
    if (v && adv && op == OP_INPUTB && rx_model.size() != 0) exp_q.push_back(rx_model.pop_front());
    if (v && adv && op == OP_READKEY && key_model.size() != 0) exp_q.push_back(key_model.pop_front());
    if (rp && rx_model.size() < RX_DEPTH) rx_model.push_back(rb);
    if (kp && key_model.size() < KEY_DEPTH) key_model.push_back(kb);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ovf_clr = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL reset_freeze: got %b, required 0", freeze); end
    n_cmp++; if (io_data !== 8'h00) begin n_err++; $display("FAIL reset_io_data: got %02h, required 00", io_data); end
    n_cmp++; if (io_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", io_data_valid); end
    n_cmp++; if (rx_count !== 5'd0) begin n_err++; $display("FAIL reset_rx_count: got %0d, required 0", rx_count); end
    n_cmp++; if (wait_cycles !== '0) begin n_err++; $display("FAIL reset_wait: got %0d, required 0", wait_cycles); end
    n_cmp++; if ({rx_overflow, key_overflow} !== 2'b00) begin n_err++; $display("FAIL reset_ovf: got %b, required 00", {rx_overflow, key_overflow}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_wait_rx();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL wait_rx_freeze0: got %b, required 1", freeze); end
    tick();
    n_cmp++; if (dut.state !== ST_WAIT_RX) begin n_err++; $display("FAIL wait_rx_state0: got %0d, required %0d", dut.state, ST_WAIT_RX); end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
      #1;
      n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL wait_rx_freeze%0d: got %b, required 1", i, freeze); end
      tick();
      n_cmp++; if (dut.state !== ST_WAIT_RX) begin n_err++; $display("FAIL wait_rx_state%0d: got %0d, required %0d", i, dut.state, ST_WAIT_RX); end
      n_cmp++; if (wait_cycles !== WAIT_CNT_W'(i)) begin n_err++; $display("FAIL wait_rx_count%0d: got %0d, required %0d", i, wait_cycles, i); end
    end
    // Push does not bypass in its own cycle
    cycle(1'b1, 8'h41, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL wait_rx_push_bypass: got freeze %b, required 1", freeze); end
    tick();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL wait_rx_release: got freeze %b, required 0", freeze); end
    tick();
    n_cmp++; if ({io_data_valid, io_data} !== {1'b1, 8'h41}) begin n_err++; $display("FAIL wait_rx_data: got valid %b data %02h, required 1/41", io_data_valid, io_data); end
    n_cmp++; if (wait_cycles !== WAIT_CNT_W'(5)) begin n_err++; $display("FAIL wait_rx_total: got %0d, required 5", wait_cycles); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL wait_rx_idle: got %0d, required %0d", dut.state, ST_IDLE); end
    idle();
    drain("wait_rx");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
      #1;
      n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL b2b_freeze%0d: got %b, required 0", i, freeze); end
      n_cmp++; if (rx_count !== 5'(3 - i)) begin n_err++; $display("FAIL b2b_count%0d: got %0d, required %0d", i, rx_count, 3 - i); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (rx_count !== 5'd0) begin n_err++; $display("FAIL b2b_count_end: got %0d, required 0", rx_count); end
    drain("b2b");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h20 + 8'(i), 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if ({rx_overflow, rx_count} !== {1'b0, 5'd16}) begin n_err++; $display("FAIL ovf_fill: got ovf %b count %0d, required 0/16", rx_overflow, rx_count); end
    cycle(1'b1, 8'hFF, 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({rx_overflow, rx_count} !== {1'b1, 5'd16}) begin n_err++; $display("FAIL ovf_drop: got ovf %b count %0d, required 1/16", rx_overflow, rx_count); end
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, required 0", rx_overflow); end
    // Push with pop on a full FIFO: head (first byte) leaves, 0x55 enters
    cycle(1'b1, 8'h55, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
    tick();
    n_cmp++; if ({rx_overflow, rx_count} !== {1'b0, 5'd16}) begin n_err++; $display("FAIL ovf_push_pop: got ovf %b count %0d, required 0/16", rx_overflow, rx_count); end
    // Drop and clear together: set wins
    cycle(1'b1, 8'hEE, 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b, required 1", rx_overflow); end
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if ({rx_overflow, key_overflow} !== 2'b00) begin n_err++; $display("FAIL ovf_clear2: got %b, required 00", {rx_overflow, key_overflow}); end
    drain("ovf");
  endtask

  task automatic test_key();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_READKEY, 1'b1, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL key_freeze: got %b, required 1", freeze); end
    tick();
    n_cmp++; if (dut.state !== ST_WAIT_KEY) begin n_err++; $display("FAIL key_state: got %0d, required %0d", dut.state, ST_WAIT_KEY); end
    cycle(1'b0, 8'h00, 1'b1, 8'h1C, OP_READKEY, 1'b1, 1'b1);
    tick();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_READKEY, 1'b1, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL key_release: got %b, required 0", freeze); end
    tick();
    n_cmp++; if ({io_data_valid, io_data} !== {1'b1, 8'h1C}) begin n_err++; $display("FAIL key_data: got valid %b data %02h, required 1/1c", io_data_valid, io_data); end
    idle();
    drain("key");
    n_cmp++; if (rx_count !== 5'd16) begin n_err++; $display("FAIL key_rx_untouched: got %0d, required 16", rx_count); end
    // Key FIFO overflow, then read it back in order
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 8'h60 + 8'(i), 6'h00, 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if ({key_overflow, rx_overflow} !== 2'b10) begin n_err++; $display("FAIL key_ovf: got key/rx %b, required 10", {key_overflow, rx_overflow}); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_READKEY, 1'b1, 1'b1);
      tick();
    end
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (key_overflow !== 1'b0) begin n_err++; $display("FAIL key_ovf_clr: got %b, required 0", key_overflow); end
    drain("key_fifo");
    // Empty RX for the flush scenario
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
      tick();
    end
    idle();
    drain("rx_empty");
    n_cmp++; if (rx_count !== 5'd0) begin n_err++; $display("FAIL rx_emptied: got %0d, required 0", rx_count); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b1);
    tick();
    n_cmp++; if (dut.state !== ST_WAIT_RX) begin n_err++; $display("FAIL flush_wait: got %0d, required %0d", dut.state, ST_WAIT_RX); end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b0, 1'b1);
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL flush_freeze: got %b, required 0", freeze); end
    tick();
    n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL flush_state: got %0d, required %0d", dut.state, ST_IDLE); end
    n_cmp++; if (io_data_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_pop: got %b, required 0", io_data_valid); end
    // Data present but decode held by another stall: no pop, no freeze
    cycle(1'b1, 8'h77, 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
    tick();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_INPUTB, 1'b1, 1'b0);
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL hold_freeze: got %b, required 0", freeze); end
    tick();
    n_cmp++; if ({io_data_valid, rx_count} !== {1'b0, 5'd1}) begin n_err++; $display("FAIL hold_no_pop: got valid %b count %0d, required 0/1", io_data_valid, rx_count); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h90 + 8'(i), 1'b0, 8'h00, 6'h00, 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if (rx_count !== 5'd5) begin n_err++; $display("FAIL rst_buffered: got %0d, required 5", rx_count); end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, OP_READKEY, 1'b1, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL rst_freeze: got %b, required 0", freeze); end
    n_cmp++; if (rx_count !== 5'd0) begin n_err++; $display("FAIL rst_count_async: got %0d, required 0", rx_count); end
    rx_model.delete();
    key_model.delete();
    exp_q.delete();
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({io_data_valid, rx_count} !== {1'b0, 5'd0}) begin n_err++; $display("FAIL rst_release: got valid %b count %0d, required 0/0", io_data_valid, rx_count); end
    n_cmp++; if (wait_cycles !== '0) begin n_err++; $display("FAIL rst_wait: got %0d, required 0", wait_cycles); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d, required %0d", dut.state, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_wait_rx();
    test_back_to_back();
    test_overflow();
    test_key();
    test_flush();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_wait_controller.md
Name: io_wait_controller

Overview:
- Owns the two blocking input sources of the CPU: UART receive bytes and keyboard scan codes.
- Buffers each source in its own FIFO and raises freeze while the decode-stage INPUTB or READKEY instruction has no data available.
- Pops one entry when the instruction advances and presents the value to writeback one cycle later.
- Replaces the ad-hoc rx_wait/key_status stall path with a sequenced, buffered controller.

Parameters:
- RX_DEPTH, 16, RX FIFO entries (power of two, >=2)
- KEY_DEPTH, 4, key FIFO entries (power of two, >=2)
- WAIT_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  decode-stage instruction; op = inst[31:26]
- inst_valid  in  1  inst holds a real instruction (not a bubble)
- advance  in  1  pipeline moves decode forward this cycle (other stalls deasserted)
- rx_push  in  1  one-cycle strobe from UART receiver
- rx_byte  in  8  received byte, valid with rx_push
- key_push  in  1  one-cycle strobe from keyboard decoder
- key_code  in  8  scan code, valid with key_push
- ovf_clr  in  1  clears both overflow flags
- freeze  out  1  stall request to pipeline
- io_data  out  8  value for INPUTB/READKEY writeback
- io_data_valid  out  1  one-cycle strobe with io_data
- rx_overflow  out  1  sticky: RX byte dropped
- key_overflow  out  1  sticky: key code dropped
- rx_count  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
- wait_cycles  out  WAIT_CNT_W  saturating count of frozen cycles since reset

Behaviour:
- Reset (async, rst_n=0):
  - both FIFOs empty, FSM=IDLE;
  - io_data=0, io_data_valid=0, overflow flags=0, wait_cycles=0;
  - freeze forced 0 while rst_n=0.
- Decode terms: is_rx = inst_valid && op==INPUTB; is_key = inst_valid && op==READKEY.
- freeze is combinational:
  - freeze = (is_rx && rx_empty) || (is_key && key_empty);
  - occupancy is the registered value, so a push in the same cycle does not bypass;
  - freeze falls on the cycle after the push.
- FSM states IDLE, WAIT_RX, WAIT_KEY:
  - IDLE -> WAIT_RX when is_rx && rx_empty;
  - IDLE -> WAIT_KEY when is_key && key_empty;
  - WAIT_x -> IDLE when that FIFO becomes non-empty, or when the instruction changes (flush/bubble). The state is re-evaluated every cycle from inst.
  - wait_cycles increments on every cycle with state != IDLE and saturates at all-ones.
- Pop:
  - when is_rx && !rx_empty && advance, pop RX head; io_data <= head, io_data_valid <= 1 on the next edge;
  - READKEY is handled the same way on the key FIFO;
  - otherwise io_data_valid <= 0 and io_data holds its last value.
  - At most one pop per cycle, because the two opcodes are exclusive.
- Push:
  - rx_push writes rx_byte when the FIFO is not full;
  - push and pop in the same cycle on a full FIFO: both happen and the count is unchanged;
  - push when full without a pop: data dropped, rx_overflow <= 1;
  - the key FIFO follows the same rules.
- Overflow: ovf_clr clears both flags. If ovf_clr and a new overflow occur in the same cycle, the flag is set (set wins).
- FIFO order: strict FIFO; pointers wrap modulo depth; count saturates at depth and never goes negative.
- Non-blocking cases: advance=0 with data present means no pop and freeze=0; the instruction is stalled by another source.
- Latency:
  - push to freeze release: 1 cycle;
  - pop to io_data_valid: 1 cycle.

Decomposition:
- Shared package/header holds:
  - INPUTB and READKEY 6-bit opcodes (existing opcode constants, not duplicated);
  - FSM state encoding (IDLE/WAIT_RX/WAIT_KEY, 2 bits).
- One natural sub-module: io_sync_fifo (parameterised width=8, depth), with push/pop/full/empty/count/head. It is instantiated twice, and drop-on-full overflow detection lives inside it.
- The FSM, freeze logic, pop steering and wait counter stay in the top module.

Test Plan:
1. Reset, then INPUTB in decode with inst_valid=1, advance=1, no push. Expect freeze=1 and state WAIT_RX each cycle; wait_cycles counts 1,2,3. Then rx_push 0x41: freeze=0 the next cycle, pop, and io_data=0x41 with io_data_valid=1 one cycle later.
2. Push 0x10,0x11,0x12, then three INPUTB with advance=1. Expect io_data 0x10,0x11,0x12 in order; freeze stays 0 throughout; rx_count goes 3->0.
3. Fill RX with 16 pushes, then a 17th push 0xFF. Expect rx_overflow=1, rx_count=16, and the head still the first byte. Then push together with a pop on a full FIFO: count stays 16 and no new overflow. Then ovf_clr clears rx_overflow.
4. READKEY with the key FIFO empty while RX holds data. Expect freeze=1 and state WAIT_KEY. Then key_push 0x1C: freeze falls, io_data=0x1C, and RX is untouched.
5. INPUTB frozen, then inst_valid drops (flush). Expect freeze=0 the same cycle, state IDLE next, and no pop.
6. Assert rst_n=0 mid-wait with 5 bytes buffered. Expect freeze=0 immediately, and rx_count=0, io_data_valid=0 and wait_cycles=0 after release.
